// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with arbitrary depth, programmable almost-full/empty thresholds,
// occupancy count, sticky overflow/underflow flags and optional first-word-fall-through read.
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            rd_valid,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overflow,
    output logic                            underflow,
    input  logic                            clr_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic [CW-1:0]         count_next_s;
    logic [PW-1:0]         wr_ptr_next_s;
    logic [PW-1:0]         rd_ptr_next_s;

    // Pointers wrap at the last physical entry, so any depth works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Accept decisions and next-state arithmetic from pre-edge registered state.
    always_comb begin
        rd_acc_s = rd_en && !empty_r;
        wr_acc_s = wr_en && (!full_r || rd_acc_s);

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase

        if (wr_acc_s) begin
            wr_ptr_next_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (rd_acc_s) begin
            rd_ptr_next_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Control state; flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            count_r        <= count_next_s;
            full_r         <= (count_next_s == DEPTH_C);
            empty_r        <= (count_next_s == {CW{1'b0}});
            almost_full_r  <= (count_next_s >= AF_C);
            almost_empty_r <= (count_next_s <= AE_C);
            // A new error event takes priority over a coincident clear.
            if (wr_en && !wr_acc_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (rd_en && !rd_acc_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero while nothing is stored.
            assign rdata    = empty_r ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];
            assign rd_valid = !empty_r;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_r;
            logic                  rd_valid_r;

            // One-cycle registered read; rdata holds between accepted reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_r    <= {DATA_WIDTH{1'b0}};
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_valid_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        rdata_r <= mem_r[rd_ptr_r];
                    end
                end
            end

            assign rdata    = rdata_r;
            assign rd_valid = rd_valid_r;
        end
    endgenerate

    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
